// File: rtl/mmss_stopwatch_pkg.sv
// rtl/mmss_stopwatch_pkg.sv - shared types and constants for the MM:SS stopwatch
// Contents: state_t (IDLE/RUN/PAUSE), BCD digit width, low-digit maximum,
// and the digit indices used to address the packed {min_hi, min_lo, sec_hi, sec_lo} bus.
package mmss_stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int BCD_W        = 4;
    localparam int DIGIT_MAX_LO = 9;

    // Digit index i occupies digits[i*BCD_W +: BCD_W]
    localparam int DIG_SEC_LO = 0;
    localparam int DIG_SEC_HI = 1;
    localparam int DIG_MIN_LO = 2;
    localparam int DIG_MIN_HI = 3;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one wrapping BCD digit with carry-enable output
// Ports: clk, rst (async, active-low), clr (sync zero), en (count enable),
//        max (wrap value), q (digit value), carry (en & q==max).
module bcd_digit
    import mmss_stopwatch_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [BCD_W-1:0] max,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    logic [BCD_W-1:0] q_q;
    logic [BCD_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            // Any value at or beyond the wrap point (including non-BCD) goes to 0
            if (q_q >= max || q_q > BCD_W'(DIGIT_MAX_LO)) begin
                q_d = '0;
            end else begin
                q_d = q_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = en & (q_q == max);

endmodule

// File: rtl/mmss_stopwatch.sv
// rtl/mmss_stopwatch.sv - MM:SS BCD stopwatch with run/pause/clear control
// Ports: clk, rst (async, active-low), tick_in (time-base level), start_stop,
//        clear, [lap when MMSS_STOPWATCH_LAP_EN], digits {min_hi,min_lo,sec_hi,sec_lo},
//        running, rollover.
// Optional macro: MMSS_STOPWATCH_LAP_EN adds the lap/freeze display feature.
module mmss_stopwatch
    import mmss_stopwatch_pkg::*;
#(
    parameter int MIN_HI_MAX = 5,
    parameter int SEC_HI_MAX = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        start_stop,
    input  logic        clear,
`ifdef MMSS_STOPWATCH_LAP_EN
    input  logic        lap,
`endif
    output logic [15:0] digits,
    output logic        running,
    output logic        rollover
);

    state_t state_q, state_d;
    logic   tick_q;
    logic   running_q, running_d;
    logic   rollover_q, rollover_d;
    logic   tick_evt;
    logic   count_en;

    logic [15:0]      live;
    logic [3:0]       carry;
    logic [3:0]       en;
    logic [BCD_W-1:0] dmax [4];

    // tick_q resets low, but the FSM also resets to IDLE, so a level that is
    // already high at reset release can never be counted.
    assign tick_evt = tick_in & ~tick_q;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else if (start_stop) begin
            case (state_q)
                ST_RUN:  state_d = ST_PAUSE;
                default: state_d = ST_RUN;
            endcase
        end
        // Counting keys off the registered state so a start/stop in the
        // same cycle as a tick only counts if we were already running.
        count_en   = (state_q == ST_RUN) & tick_evt & ~clear;
        running_d  = (state_d == ST_RUN);
        rollover_d = carry[DIG_MIN_HI];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_in;
            running_q  <= running_d;
            rollover_q <= rollover_d;
        end
    end

    assign dmax[DIG_SEC_LO] = BCD_W'(DIGIT_MAX_LO);
    assign dmax[DIG_SEC_HI] = BCD_W'(SEC_HI_MAX);
    assign dmax[DIG_MIN_LO] = BCD_W'(DIGIT_MAX_LO);
    assign dmax[DIG_MIN_HI] = BCD_W'(MIN_HI_MAX);

    // Ripple of carry enables: every digit updates on the same edge
    assign en = {carry[2:0], count_en};

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .en    (en[i]),
            .max   (dmax[i]),
            .q     (live[i*BCD_W +: BCD_W]),
            .carry (carry[i])
        );
    end

`ifdef MMSS_STOPWATCH_LAP_EN
    logic        frozen_q, frozen_d;
    logic [15:0] lap_q, lap_d;

    always_comb begin
        frozen_d = frozen_q;
        lap_d    = lap_q;
        if (clear || (state_q == ST_RUN && start_stop)) begin
            frozen_d = 1'b0;
        end else if (state_q == ST_RUN && lap) begin
            frozen_d = ~frozen_q;
            if (!frozen_q) begin
                lap_d = live;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frozen_q <= 1'b0;
            lap_q    <= '0;
        end else begin
            frozen_q <= frozen_d;
            lap_q    <= lap_d;
        end
    end

    assign digits = frozen_q ? lap_q : live;
`else
    assign digits = live;
`endif

    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_mmss_stopwatch.sv
// tb/tb_mmss_stopwatch.sv - self-checking bench for mmss_stopwatch
module tb_mmss_stopwatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        rollover;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: elapsed seconds as a plain integer plus a mode variable
    int          m_secs    = 0;
    int          m_mode    = 0;   // 0 idle, 1 run, 2 pause
    bit          m_prev    = 1'b0;
    bit          m_roll    = 1'b0;
    bit          m_running = 1'b0;

    mmss_stopwatch #(.MIN_HI_MAX(5), .SEC_HI_MAX(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_in    (tick_in),
        .start_stop (start_stop),
        .clear      (clear),
        .digits     (digits),
        .running    (running),
        .rollover   (rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int s);
        int mm;
        int ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_secs = 0; m_mode = 0; m_prev = 1'b0; m_roll = 1'b0; m_running = 1'b0;
        end else begin
            bit evt;
            evt    = tick_in && !m_prev;
            m_prev = tick_in;
            m_roll = 1'b0;
            if (clear) begin
                m_secs = 0;
                m_mode = 0;
            end else begin
                if (m_mode == 1 && evt) begin
                    m_secs = m_secs + 1;
                    if (m_secs == 3600) begin
                        m_secs = 0;
                        m_roll = 1'b1;
                    end
                end
                if (start_stop) m_mode = (m_mode == 1) ? 2 : 1;
            end
            m_running = (m_mode == 1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_digits",   digits,          to_bcd(m_secs));
            check("model_running",  16'(running),    16'(m_running));
            check("model_rollover", 16'(rollover),   16'(m_roll));
        end
    end

    task automatic tick();
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk) tick_in = 1'b0;
    endtask

    task automatic press_ss();
        @(negedge clk) start_stop = 1'b1;
        @(negedge clk) start_stop = 1'b0;
    endtask

    task automatic press_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_digits",   digits,        16'h0000);
        check("reset_running",  16'(running),  16'h0);
        check("reset_rollover", 16'(rollover), 16'h0);
        rst = 1'b1;
        chk_en = 1'b1;

        // Start and count ten seconds
        press_ss();
        check("start_running", 16'(running), 16'h1);
        for (int i = 0; i < 10; i++) tick();
        check("ten_ticks", digits, 16'h0010);

        // Held level counts once
        @(negedge clk) tick_in = 1'b1;
        repeat (20) @(negedge clk);
        tick_in = 1'b0;
        @(negedge clk);
        check("held_level", digits, 16'h0011);

        // Preload to 59:58 then wrap
        press_clear();
        check("clear_digits",  digits,       16'h0000);
        check("clear_running", 16'(running), 16'h0);
        press_ss();
        for (int i = 0; i < 3598; i++) tick();
        check("preload_5958", digits, 16'h5958);
        tick();
        check("max_5959", digits, 16'h5959);
        check("max_no_roll", 16'(rollover), 16'h0);
        @(negedge clk) tick_in = 1'b1;
        @(negedge clk) tick_in = 1'b0;
        check("wrap_digits",   digits,        16'h0000);
        check("wrap_rollover", 16'(rollover), 16'h1);
        @(negedge clk);
        check("rollover_one_cycle", 16'(rollover), 16'h0);

        // Tick edge with start_stop from RUN: counted, then paused
        @(negedge clk) begin tick_in = 1'b1; start_stop = 1'b1; end
        @(negedge clk) begin tick_in = 1'b0; start_stop = 1'b0; end
        check("run_ss_tick_digits",  digits,       16'h0001);
        check("run_ss_tick_running", 16'(running), 16'h0);
        // Same from PAUSE: not counted, resumes
        @(negedge clk) begin tick_in = 1'b1; start_stop = 1'b1; end
        @(negedge clk) begin tick_in = 1'b0; start_stop = 1'b0; end
        check("pause_ss_tick_digits",  digits,       16'h0001);
        check("pause_ss_tick_running", 16'(running), 16'h1);
        tick();
        check("resume_count", digits, 16'h0002);

        // Reach 01:23, then clear and start_stop together
        for (int i = 0; i < 81; i++) tick();
        check("at_0123", digits, 16'h0123);
        @(negedge clk) begin clear = 1'b1; start_stop = 1'b1; end
        @(negedge clk) begin clear = 1'b0; start_stop = 1'b0; end
        check("clr_ss_digits",  digits,       16'h0000);
        check("clr_ss_running", 16'(running), 16'h0);
        tick();
        check("idle_no_count", digits, 16'h0000);

        // Reach 03:45, then asynchronous reset between edges
        press_ss();
        for (int i = 0; i < 225; i++) tick();
        check("at_0345", digits, 16'h0345);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_digits",  digits,       16'h0000);
        check("async_rst_running", 16'(running), 16'h0);
        tick_in = 1'b1;
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        press_ss();
        repeat (3) @(negedge clk);
        check("high_at_release_no_count", digits, 16'h0000);
        check("run_after_reset", 16'(running), 16'h1);
        tick_in = 1'b0;
        tick();
        check("count_after_reset", digits, 16'h0001);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
